// File: rtl/flit_to_packet_multi_vc_if.sv
// Flit/packet types and the bundled router-side / consumer-side signals of the
// multi-VC reassembler.
package flit_to_packet_multi_vc_pkg;
  localparam int unsigned PAYLOAD_W  = 64;
  localparam int unsigned VC_FIELD_W = 4;

  typedef enum logic [1:0] {HEADER = 2'd0, BODY = 2'd1, TAIL = 2'd2, HT = 2'd3} flit_type_t;
  typedef enum logic [1:0] {TO_NONE = 2'd0, TO_CC = 2'd1, TO_DC = 2'd2, TO_RSVD = 2'd3} core_dest_t;

  typedef struct packed {
    flit_type_t              flit_type;
    logic [VC_FIELD_W-1:0]   vc;
    core_dest_t              core_destination;
  } flit_header_t;

  typedef struct packed {
    flit_header_t            header;
    logic [PAYLOAD_W-1:0]    payload;
  } flit_t;
endpackage

interface flit_to_packet_multi_vc_if
  import flit_to_packet_multi_vc_pkg::*;
#(
  parameter int unsigned PACKET_BODY_SIZE = 256,
  parameter int unsigned VC_NUM           = 4
);
  localparam int unsigned VC_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

  logic                        enable;
  logic                        router_flit_valid;
  flit_t                       router_flit_in;
  logic [VC_NUM-1:0]           ni_vc_full;
  logic                        out_packet_valid;
  logic                        out_packet_ready;
  logic [PACKET_BODY_SIZE-1:0] out_packet_body;
  logic [VC_W-1:0]             out_packet_vc;
  logic                        out_is_for_cc;
  logic                        out_is_for_dc;
  logic                        out_packet_truncated;
  logic                        err_flit_drop;
  logic [VC_W-1:0]             err_vc;

  modport master (
    input  enable, router_flit_valid, router_flit_in, out_packet_ready,
    output ni_vc_full, out_packet_valid, out_packet_body, out_packet_vc,
           out_is_for_cc, out_is_for_dc, out_packet_truncated, err_flit_drop, err_vc
  );

  modport slave (
    output enable, router_flit_valid, router_flit_in, out_packet_ready,
    input  ni_vc_full, out_packet_valid, out_packet_body, out_packet_vc,
           out_is_for_cc, out_is_for_dc, out_packet_truncated, err_flit_drop, err_vc
  );
endinterface

// File: rtl/flit_to_packet_multi_vc.sv
// Per-VC flit reassembly with a round-robin arbitrated, single-stage packet
// output register and registered drop reporting.
module flit_to_packet_multi_vc
  import flit_to_packet_multi_vc_pkg::*;
#(
  parameter int unsigned PACKET_BODY_SIZE = 256,
  parameter int unsigned VC_NUM           = 4
) (
  input logic                      clk,
  input logic                      reset,
  flit_to_packet_multi_vc_if.master bus
);
  localparam int unsigned FLIT_NUMB = (PACKET_BODY_SIZE + PAYLOAD_W - 1) / PAYLOAD_W;
  localparam int unsigned BUF_W     = FLIT_NUMB * PAYLOAD_W;
  localparam int unsigned CNT_W     = $clog2(FLIT_NUMB + 1);
  localparam int unsigned SEG_W     = (FLIT_NUMB > 1) ? $clog2(FLIT_NUMB) : 1;
  localparam int unsigned VC_W      = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_FULL} vc_state_t;
  typedef logic [FLIT_NUMB-1:0][PAYLOAD_W-1:0] seg_buf_t;

  vc_state_t         state   [VC_NUM];
  seg_buf_t          seg_buf [VC_NUM];
  logic [CNT_W-1:0]  cnt     [VC_NUM];
  logic [VC_NUM-1:0] dest_cc, dest_dc, trunc;
  logic [VC_W-1:0]   rr_ptr;

  logic                        out_valid, out_cc, out_dc, out_trunc, err_drop;
  logic [PACKET_BODY_SIZE-1:0] out_body;
  logic [VC_W-1:0]             out_vc, err_vc_q;

  flit_t             flit;
  logic              accept, fvc_ok, is_head, drop, load, gnt_any;
  logic [VC_W-1:0]   fvc, gnt_idx, cand, next_ptr;
  logic [VC_NUM-1:0] hit, full_vec;
  logic [BUF_W-1:0]  gnt_buf;

  assign flit    = bus.router_flit_in;
  assign accept  = bus.enable && bus.router_flit_valid;
  assign fvc_ok  = 32'(flit.header.vc) < VC_NUM;
  assign fvc     = flit.header.vc[VC_W-1:0];
  assign is_head = (flit.header.flit_type == HEADER) || (flit.header.flit_type == HT);

  always_comb begin
    hit      = '0;
    full_vec = '0;
    drop     = accept && !fvc_ok;
    for (int unsigned v = 0; v < VC_NUM; v++) begin
      hit[VC_W'(v)]      = accept && fvc_ok && (fvc == VC_W'(v));
      full_vec[VC_W'(v)] = (state[VC_W'(v)] == S_FULL);
      if (hit[VC_W'(v)]) begin
        if (state[VC_W'(v)] == S_FULL) drop = 1'b1;
        else if (state[VC_W'(v)] == S_IDLE && !is_head) drop = 1'b1;
        else if (state[VC_W'(v)] == S_COLLECT && is_head) drop = 1'b1;
      end
    end
  end

  // Round-robin: rr_ptr is the first candidate examined, one past the last grant.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned i = 0; i < VC_NUM; i++) begin
      cand = VC_W'((32'(rr_ptr) + i) % VC_NUM);
      if (!gnt_any && state[cand] == S_FULL) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign next_ptr = (gnt_idx == VC_W'(VC_NUM - 1)) ? '0 : gnt_idx + 1'b1;
  assign gnt_buf  = seg_buf[gnt_idx];
  assign load     = !out_valid || bus.out_packet_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned v = 0; v < VC_NUM; v++) begin
        state[VC_W'(v)]   <= S_IDLE;
        seg_buf[VC_W'(v)] <= '0;
        cnt[VC_W'(v)]     <= '0;
      end
      dest_cc   <= '0;
      dest_dc   <= '0;
      trunc     <= '0;
      rr_ptr    <= '0;
      out_valid <= 1'b0;
      out_body  <= '0;
      out_vc    <= '0;
      out_cc    <= 1'b0;
      out_dc    <= 1'b0;
      out_trunc <= 1'b0;
      err_drop  <= 1'b0;
      err_vc_q  <= '0;
    end else begin
      err_drop <= drop;
      if (drop) err_vc_q <= fvc;

      for (int unsigned v = 0; v < VC_NUM; v++) begin
        if (hit[VC_W'(v)]) begin
          if (state[VC_W'(v)] != S_FULL && is_head) begin
            seg_buf[VC_W'(v)]    <= '0;
            seg_buf[VC_W'(v)][0] <= flit.payload;
            cnt[VC_W'(v)]        <= CNT_W'(1);
            dest_cc[VC_W'(v)]    <= (flit.header.core_destination == TO_CC);
            dest_dc[VC_W'(v)]    <= (flit.header.core_destination == TO_DC);
            trunc[VC_W'(v)]      <= 1'b0;
            state[VC_W'(v)]      <= (flit.header.flit_type == HT) ? S_FULL : S_COLLECT;
          end else if (state[VC_W'(v)] == S_COLLECT) begin
            // Beyond FLIT_NUMB the payload is discarded and the count saturates.
            if (cnt[VC_W'(v)] < CNT_W'(FLIT_NUMB)) begin
              for (int unsigned s = 0; s < FLIT_NUMB; s++)
                if (cnt[VC_W'(v)] == CNT_W'(s)) seg_buf[VC_W'(v)][SEG_W'(s)] <= flit.payload;
              cnt[VC_W'(v)] <= cnt[VC_W'(v)] + 1'b1;
            end else begin
              trunc[VC_W'(v)] <= 1'b1;
            end
            if (flit.header.flit_type == TAIL) state[VC_W'(v)] <= S_FULL;
          end
        end
      end

      if (load) begin
        out_valid <= gnt_any;
        if (gnt_any) begin
          out_body       <= gnt_buf[PACKET_BODY_SIZE-1:0];
          out_vc         <= gnt_idx;
          out_cc         <= dest_cc[gnt_idx];
          out_dc         <= dest_dc[gnt_idx];
          out_trunc      <= trunc[gnt_idx];
          state[gnt_idx] <= S_IDLE;
          rr_ptr         <= next_ptr;
        end
      end
    end
  end

  assign bus.ni_vc_full           = full_vec;
  assign bus.out_packet_valid     = out_valid;
  assign bus.out_packet_body      = out_body;
  assign bus.out_packet_vc        = out_vc;
  assign bus.out_is_for_cc        = out_cc;
  assign bus.out_is_for_dc        = out_dc;
  assign bus.out_packet_truncated = out_trunc;
  assign bus.err_flit_drop        = err_drop;
  assign bus.err_vc               = err_vc_q;
endmodule

// File: tb/tb_flit_to_packet_multi_vc.sv
// Directed scenarios plus randomized traffic checked against a packet-level
// reference model of the multi-VC reassembler.
module tb_flit_to_packet_multi_vc;
  import flit_to_packet_multi_vc_pkg::*;

  localparam int unsigned PBS = 256;
  localparam int NVC = 4;

  logic clk, reset;
  flit_to_packet_multi_vc_if #(.PACKET_BODY_SIZE(PBS), .VC_NUM(NVC)) bus ();

  flit_to_packet_multi_vc #(.PACKET_BODY_SIZE(PBS), .VC_NUM(NVC)) dut (
    .clk(clk), .reset(reset), .bus(bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks, n_fail, err_seen;
  logic [255:0] cap_body[$];
  int           cap_vc[$];
  bit           cap_tr[$];

  // Reference model: per-VC packet under construction, completed flag, and output slot.
  bit          m_open[NVC], m_done[NVC], m_trunc[NVC], m_cc[NVC], m_dc[NVC];
  logic [63:0] m_seg[NVC][4];
  int          m_n[NVC];
  int          m_ptr, m_ovc;
  bit          m_ov, m_occ, m_odc, m_otr, m_err;
  logic [255:0] m_obody;
  logic [1:0]  m_errvc;

  function automatic logic [255:0] model_body(int w);
    logic [255:0] b;
    b = '0;
    for (int i = 0; i < m_n[w]; i++) b |= 256'(m_seg[w][i]) << (64 * i);
    return b;
  endfunction

  task automatic model_update();
    int w;
    w = -1;
    if (reset) begin
      for (int v = 0; v < NVC; v++) begin
        m_open[v] = 0; m_done[v] = 0; m_n[v] = 0; m_trunc[v] = 0; m_cc[v] = 0; m_dc[v] = 0;
      end
      m_ptr = 0; m_ov = 0; m_obody = '0; m_ovc = 0; m_occ = 0; m_odc = 0; m_otr = 0;
      m_err = 0; m_errvc = '0;
      return;
    end
    if (!m_ov || bus.out_packet_ready) begin
      for (int k = 0; k < NVC; k++)
        if (w < 0 && m_done[(m_ptr + k) % NVC]) w = (m_ptr + k) % NVC;
      m_ov = (w >= 0);
      if (w >= 0) begin
        m_obody = model_body(w); m_ovc = w; m_occ = m_cc[w]; m_odc = m_dc[w];
        m_otr = m_trunc[w]; m_ptr = (w + 1) % NVC;
      end
    end
    m_err = 0;
    if (bus.enable && bus.router_flit_valid) begin
      int v;
      flit_type_t t;
      v = int'(bus.router_flit_in.header.vc);
      t = bus.router_flit_in.header.flit_type;
      if (v >= NVC) m_err = 1;
      else if (m_done[v]) m_err = 1;
      else if (t == HEADER || t == HT) begin
        if (m_open[v]) m_err = 1;
        m_seg[v][0] = bus.router_flit_in.payload; m_n[v] = 1; m_trunc[v] = 0;
        m_cc[v] = (bus.router_flit_in.header.core_destination == TO_CC);
        m_dc[v] = (bus.router_flit_in.header.core_destination == TO_DC);
        m_open[v] = (t == HEADER); m_done[v] = (t == HT);
      end else if (!m_open[v]) m_err = 1;
      else begin
        if (m_n[v] < 4) begin m_seg[v][m_n[v]] = bus.router_flit_in.payload; m_n[v]++; end
        else m_trunc[v] = 1;
        if (t == TAIL) begin m_open[v] = 0; m_done[v] = 1; end
      end
      if (m_err) m_errvc = bus.router_flit_in.header.vc[1:0];
    end
    if (w >= 0) m_done[w] = 0;
  endtask

  task automatic step();
    if (bus.out_packet_valid === 1'b1 && bus.out_packet_ready === 1'b1) begin
      cap_body.push_back(bus.out_packet_body);
      cap_vc.push_back(int'(bus.out_packet_vc));
      cap_tr.push_back(bus.out_packet_truncated);
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
    if (bus.err_flit_drop === 1'b1) err_seen++;
  endtask

  task automatic idle(int n);
    repeat (n) step();
  endtask

  task automatic send(flit_type_t t, int vc, core_dest_t d, logic [63:0] p);
    bus.router_flit_valid = 1'b1;
    bus.router_flit_in.header.flit_type = t;
    bus.router_flit_in.header.vc = 4'(vc);
    bus.router_flit_in.header.core_destination = d;
    bus.router_flit_in.payload = p;
    step();
    bus.router_flit_valid = 1'b0;
  endtask

  task automatic clear_caps();
    cap_body.delete(); cap_vc.delete(); cap_tr.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(2);
    n_checks++; if (bus.out_packet_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", bus.out_packet_valid); end
    n_checks++; if (bus.out_packet_body !== '0) begin n_fail++; $display("FAIL rst_body: got %h expected 0", bus.out_packet_body); end
    n_checks++; if (bus.out_packet_vc !== 2'd0) begin n_fail++; $display("FAIL rst_vc: got %0d expected 0", bus.out_packet_vc); end
    n_checks++; if ({bus.out_is_for_cc, bus.out_is_for_dc, bus.out_packet_truncated} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b expected 000", {bus.out_is_for_cc, bus.out_is_for_dc, bus.out_packet_truncated}); end
    n_checks++; if ({bus.err_flit_drop, bus.err_vc} !== 3'b000) begin n_fail++; $display("FAIL rst_err: got %b expected 000", {bus.err_flit_drop, bus.err_vc}); end
    n_checks++; if (bus.ni_vc_full !== 4'b0000) begin n_fail++; $display("FAIL rst_full: got %b expected 0000", bus.ni_vc_full); end
    reset = 1'b0;
  endtask

  task automatic test_single_ht();
    bus.out_packet_ready = 1'b1;
    send(HT, 1, TO_DC, 64'hA5);
    n_checks++; if (bus.ni_vc_full !== 4'b0010) begin n_fail++; $display("FAIL ht_full: got %b expected 0010", bus.ni_vc_full); end
    n_checks++; if (bus.out_packet_valid !== 1'b0) begin n_fail++; $display("FAIL ht_early_valid: got %b expected 0", bus.out_packet_valid); end
    step();
    n_checks++; if (bus.ni_vc_full !== 4'b0000) begin n_fail++; $display("FAIL ht_full_clr: got %b expected 0000", bus.ni_vc_full); end
    n_checks++; if (bus.out_packet_valid !== 1'b1) begin n_fail++; $display("FAIL ht_valid: got %b expected 1", bus.out_packet_valid); end
    n_checks++; if (bus.out_packet_body !== 256'hA5) begin n_fail++; $display("FAIL ht_body: got %h expected a5", bus.out_packet_body); end
    n_checks++; if ({bus.out_packet_vc, bus.out_is_for_dc, bus.out_is_for_cc} !== 4'b0110) begin n_fail++; $display("FAIL ht_meta: got %b expected 0110", {bus.out_packet_vc, bus.out_is_for_dc, bus.out_is_for_cc}); end
    step();
    n_checks++; if (bus.out_packet_valid !== 1'b0) begin n_fail++; $display("FAIL ht_drain: got %b expected 0", bus.out_packet_valid); end
  endtask

  task automatic test_interleaved();
    flit_type_t seq[4] = '{HEADER, BODY, BODY, TAIL};
    bus.out_packet_ready = 1'b1;
    clear_caps();
    for (int i = 0; i < 4; i++) begin
      send(seq[i], 0, TO_CC, 64'(i + 1));
      send(seq[i], 2, TO_CC, 64'(i + 5));
    end
    idle(4);
    n_checks++; if (cap_vc.size() !== 2) begin n_fail++; $display("FAIL il_count: got %0d expected 2", cap_vc.size()); end
    if (cap_vc.size() >= 2) begin
      n_checks++; if (cap_vc[0] !== 0 || cap_vc[1] !== 2) begin n_fail++; $display("FAIL il_order: got %0d,%0d expected 0,2", cap_vc[0], cap_vc[1]); end
      n_checks++; if (cap_body[0] !== {64'd4, 64'd3, 64'd2, 64'd1}) begin n_fail++; $display("FAIL il_body0: got %h", cap_body[0]); end
      n_checks++; if (cap_body[1] !== {64'd8, 64'd7, 64'd6, 64'd5}) begin n_fail++; $display("FAIL il_body2: got %h", cap_body[1]); end
    end
  endtask

  task automatic test_backpressure();
    bus.out_packet_ready = 1'b0;
    send(HT, 0, TO_CC, 64'hB0);
    send(HT, 1, TO_CC, 64'hB1);
    send(HT, 3, TO_DC, 64'hB3);
    idle(2);
    n_checks++; if (bus.ni_vc_full !== 4'b1010) begin n_fail++; $display("FAIL bp_full: got %b expected 1010", bus.ni_vc_full); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (bus.out_packet_valid !== 1'b1 || bus.out_packet_vc !== 2'd0 || bus.out_packet_body !== 256'hB0) begin n_fail++; $display("FAIL bp_hold: got valid=%b vc=%0d body=%h expected 1 0 b0", bus.out_packet_valid, bus.out_packet_vc, bus.out_packet_body); end
      step();
    end
    bus.out_packet_ready = 1'b1;
    step();
    n_checks++; if (bus.out_packet_valid !== 1'b1 || bus.out_packet_vc !== 2'd1 || bus.out_packet_body !== 256'hB1) begin n_fail++; $display("FAIL bp_second: got valid=%b vc=%0d body=%h expected 1 1 b1", bus.out_packet_valid, bus.out_packet_vc, bus.out_packet_body); end
    step();
    n_checks++; if (bus.out_packet_valid !== 1'b1 || bus.out_packet_vc !== 2'd3 || bus.out_is_for_dc !== 1'b1) begin n_fail++; $display("FAIL bp_third: got valid=%b vc=%0d dc=%b expected 1 3 1", bus.out_packet_valid, bus.out_packet_vc, bus.out_is_for_dc); end
    step();
    n_checks++; if (bus.out_packet_valid !== 1'b0 || bus.ni_vc_full !== 4'b0000) begin n_fail++; $display("FAIL bp_drain: got valid=%b full=%b expected 0 0000", bus.out_packet_valid, bus.ni_vc_full); end
  endtask

  task automatic test_overflow();
    bus.out_packet_ready = 1'b1;
    clear_caps();
    err_seen = 0;
    send(HEADER, 0, TO_CC, 64'h10);
    for (int i = 1; i <= 4; i++) send(BODY, 0, TO_CC, 64'(16 + i));
    send(TAIL, 0, TO_CC, 64'h15);
    idle(4);
    n_checks++; if (err_seen !== 0) begin n_fail++; $display("FAIL ovf_err: got %0d pulses expected 0", err_seen); end
    n_checks++; if (cap_vc.size() !== 1) begin n_fail++; $display("FAIL ovf_count: got %0d expected 1", cap_vc.size()); end
    if (cap_vc.size() >= 1) begin
      n_checks++; if (cap_body[0] !== {64'h13, 64'h12, 64'h11, 64'h10}) begin n_fail++; $display("FAIL ovf_body: got %h", cap_body[0]); end
      n_checks++; if (cap_tr[0] !== 1'b1) begin n_fail++; $display("FAIL ovf_trunc: got %b expected 1", cap_tr[0]); end
    end
  endtask

  task automatic test_errors();
    bus.out_packet_ready = 1'b1;
    send(BODY, 2, TO_CC, 64'h77);
    n_checks++; if (bus.err_flit_drop !== 1'b1 || bus.err_vc !== 2'd2) begin n_fail++; $display("FAIL err_idle_body: got drop=%b vc=%0d expected 1 2", bus.err_flit_drop, bus.err_vc); end
    step();
    n_checks++; if (bus.err_flit_drop !== 1'b0) begin n_fail++; $display("FAIL err_pulse_len: got %b expected 0", bus.err_flit_drop); end
    send(HEADER, 5, TO_CC, 64'h55);
    n_checks++; if (bus.err_flit_drop !== 1'b1 || bus.err_vc !== 2'd1) begin n_fail++; $display("FAIL err_bad_vc: got drop=%b vc=%0d expected 1 1", bus.err_flit_drop, bus.err_vc); end
    clear_caps();
    err_seen = 0;
    send(HEADER, 0, TO_CC, 64'h21);
    send(BODY, 0, TO_CC, 64'h22);
    send(HEADER, 0, TO_DC, 64'h31);
    send(TAIL, 0, TO_CC, 64'h32);
    idle(4);
    n_checks++; if (err_seen !== 1) begin n_fail++; $display("FAIL err_restart_pulses: got %0d expected 1", err_seen); end
    n_checks++; if (cap_vc.size() !== 1) begin n_fail++; $display("FAIL err_restart_count: got %0d expected 1", cap_vc.size()); end
    if (cap_vc.size() >= 1) begin
      n_checks++; if (cap_body[0] !== {128'd0, 64'h32, 64'h31}) begin n_fail++; $display("FAIL err_restart_body: got %h", cap_body[0]); end
    end
    bus.out_packet_ready = 1'b0;
    clear_caps();
    send(HT, 1, TO_CC, 64'h41);
    send(HT, 2, TO_CC, 64'h42);
    idle(1);
    n_checks++; if (bus.ni_vc_full !== 4'b0100) begin n_fail++; $display("FAIL err_full_state: got %b expected 0100", bus.ni_vc_full); end
    send(BODY, 2, TO_CC, 64'h99);
    n_checks++; if (bus.err_flit_drop !== 1'b1 || bus.err_vc !== 2'd2) begin n_fail++; $display("FAIL err_full_drop: got drop=%b vc=%0d expected 1 2", bus.err_flit_drop, bus.err_vc); end
    bus.out_packet_ready = 1'b1;
    idle(4);
    n_checks++; if (cap_vc.size() !== 2) begin n_fail++; $display("FAIL err_full_count: got %0d expected 2", cap_vc.size()); end
    if (cap_vc.size() >= 2) begin
      n_checks++; if (cap_vc[1] !== 2 || cap_body[1] !== 256'h42) begin n_fail++; $display("FAIL err_full_pkt: got vc=%0d body=%h expected 2 42", cap_vc[1], cap_body[1]); end
    end
  endtask

  task automatic test_reset_enable();
    bus.out_packet_ready = 1'b1;
    clear_caps();
    send(HEADER, 0, TO_CC, 64'h51);
    send(BODY, 0, TO_CC, 64'h52);
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++; if ({bus.out_packet_valid, bus.err_flit_drop, bus.ni_vc_full} !== 6'b0) begin n_fail++; $display("FAIL re_reset: got %b expected 000000", {bus.out_packet_valid, bus.err_flit_drop, bus.ni_vc_full}); end
    idle(3);
    n_checks++; if (cap_vc.size() !== 0) begin n_fail++; $display("FAIL re_no_pkt: got %0d expected 0", cap_vc.size()); end
    send(HEADER, 3, TO_CC, 64'h61);
    send(BODY, 3, TO_CC, 64'h62);
    bus.enable = 1'b0;
    send(TAIL, 3, TO_CC, 64'h63);
    bus.enable = 1'b1;
    n_checks++; if (bus.ni_vc_full !== 4'b0000 || bus.err_flit_drop !== 1'b0) begin n_fail++; $display("FAIL re_disabled: got full=%b drop=%b expected 0000 0", bus.ni_vc_full, bus.err_flit_drop); end
    idle(2);
    n_checks++; if (cap_vc.size() !== 0) begin n_fail++; $display("FAIL re_disabled_pkt: got %0d expected 0", cap_vc.size()); end
    send(TAIL, 3, TO_CC, 64'h64);
    idle(3);
    n_checks++; if (cap_vc.size() !== 1) begin n_fail++; $display("FAIL re_resume_count: got %0d expected 1", cap_vc.size()); end
    if (cap_vc.size() >= 1) begin
      n_checks++; if (cap_vc[0] !== 3 || cap_body[0] !== {64'd0, 64'h64, 64'h62, 64'h61}) begin n_fail++; $display("FAIL re_resume_pkt: got vc=%0d body=%h", cap_vc[0], cap_body[0]); end
    end
  endtask

  task automatic test_random();
    logic [3:0] mfull;
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int c = 0; c < 800; c++) begin
      bus.router_flit_valid = ($urandom_range(0, 3) != 0);
      bus.enable = ($urandom_range(0, 7) != 0);
      bus.out_packet_ready = ($urandom_range(0, 2) != 0);
      bus.router_flit_in.header.flit_type = flit_type_t'($urandom_range(0, 3));
      bus.router_flit_in.header.vc = 4'($urandom_range(0, 5));
      bus.router_flit_in.header.core_destination = core_dest_t'($urandom_range(0, 3));
      bus.router_flit_in.payload = {$urandom, $urandom};
      step();
      for (int v = 0; v < NVC; v++) mfull[v] = m_done[v];
      n_checks++; if (bus.ni_vc_full !== mfull) begin n_fail++; $display("FAIL rnd_full cyc %0d: got %b expected %b", c, bus.ni_vc_full, mfull); end
      n_checks++; if (bus.out_packet_valid !== m_ov) begin n_fail++; $display("FAIL rnd_valid cyc %0d: got %b expected %b", c, bus.out_packet_valid, m_ov); end
      if (m_ov) begin
        n_checks++; if (bus.out_packet_body !== m_obody) begin n_fail++; $display("FAIL rnd_body cyc %0d: got %h expected %h", c, bus.out_packet_body, m_obody); end
        n_checks++; if ({bus.out_packet_vc, bus.out_is_for_cc, bus.out_is_for_dc, bus.out_packet_truncated} !== {2'(m_ovc), m_occ, m_odc, m_otr}) begin n_fail++; $display("FAIL rnd_meta cyc %0d: got %b expected %b", c, {bus.out_packet_vc, bus.out_is_for_cc, bus.out_is_for_dc, bus.out_packet_truncated}, {2'(m_ovc), m_occ, m_odc, m_otr}); end
      end
      n_checks++; if (bus.err_flit_drop !== m_err) begin n_fail++; $display("FAIL rnd_err cyc %0d: got %b expected %b", c, bus.err_flit_drop, m_err); end
      if (m_err) begin
        n_checks++; if (bus.err_vc !== m_errvc) begin n_fail++; $display("FAIL rnd_err_vc cyc %0d: got %0d expected %0d", c, bus.err_vc, m_errvc); end
      end
    end
    bus.router_flit_valid = 1'b0;
    bus.enable = 1'b1;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; err_seen = 0;
    reset = 1'b1;
    bus.enable = 1'b1;
    bus.router_flit_valid = 1'b0;
    bus.router_flit_in = '0;
    bus.out_packet_ready = 1'b0;
    test_reset();
    test_single_ht();
    test_interleaved();
    test_backpressure();
    test_overflow();
    test_errors();
    test_reset_enable();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/flit_to_packet_multi_vc.md
# flit_to_packet_multi_vc

Multi-virtual-channel flit-to-packet reassembler for the network interface. It sits between the router ejection port and the NI packet consumers. Flits from up to `VC_NUM` virtual channels may arrive interleaved; each VC is reassembled independently. Completed packets are presented one at a time on a valid/ready output, selected by round-robin arbitration. Each packet carries its destination decode and a truncation flag.

## Interface
- `PACKET_BODY_SIZE`, 256, packet body width in bits.
- `VC_NUM`, 4, number of virtual channels, ≥1.
- `FLIT_NUMB`, derived, equals (`PACKET_BODY_SIZE` + `PAYLOAD_W` − 1) / `PAYLOAD_W`. It is a localparam.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: flit acceptance enable.
- `router_flit_valid` in 1: flit present.
- `router_flit_in` in `flit_t`: flit, using header `flit_type`, `vc`, `core_destination` and `payload`.
- `ni_vc_full` out `VC_NUM`: bit v is high while VC v holds a completed, unconsumed packet. This is on/off backpressure to the router.
- `out_packet_valid` out 1: output packet valid.
- `out_packet_ready` in 1: consumer accepts.
- `out_packet_body` out `PACKET_BODY_SIZE`: reassembled body.
- `out_packet_vc` out $clog2(`VC_NUM`) (min 1): source VC.
- `out_is_for_cc`, `out_is_for_dc` out 1: from the HEADER/HT `core_destination` (TO_CC / TO_DC).
- `out_packet_truncated` out 1: the packet had more than `FLIT_NUMB` flits.
- `err_flit_drop` out 1: one-cycle pulse when a flit is discarded.
- `err_vc` out $clog2(`VC_NUM`): VC of the dropped flit; valid while `err_flit_drop` is high.

## Operation

**Per-VC state.** Each VC has a state (IDLE, COLLECT, FULL), a `FLIT_NUMB`×`PAYLOAD_W` buffer, a count of width $clog2(`FLIT_NUMB`+1), a destination pair and a truncated bit.

**Flit acceptance.** A flit is accepted when `enable` and `router_flit_valid` are both high. It is steered by `header.vc`; a `vc` ≥ `VC_NUM` is dropped.

| VC state | Flit type | Action |
|---|---|---|
| IDLE | HEADER | Clear buffer. Store payload in segment 0. count=1. Latch destination. truncated=0. Go to COLLECT. |
| IDLE | HT | As HEADER, then go directly to FULL. |
| IDLE | BODY / TAIL | Drop. |
| COLLECT | BODY | Store in segment count, count+1. |
| COLLECT | TAIL | Store in segment count, count+1, then go to FULL. |
| COLLECT | HEADER / HT | Discard the partial packet, restart as from IDLE, and pulse `err_flit_drop`. |
| FULL | any | Drop. |

**Overflow.** If count = `FLIT_NUMB` when BODY or TAIL arrives, the payload is discarded and count saturates. Truncated is set; this is not a drop error. A TAIL still completes the packet.

**Short packets.** Unwritten segments read as zero.

**Body mapping.** Segment i maps to bits [i·`PAYLOAD_W` +: `PAYLOAD_W`]. The last segment contributes only its low `PACKET_BODY_SIZE` − (`FLIT_NUMB`−1)·`PAYLOAD_W` bits. This must also be correct when `PACKET_BODY_SIZE` is an exact multiple of `PAYLOAD_W`.

**Output register.** The output is a single register stage. It loads when it is empty or when `out_packet_valid` and `out_packet_ready` are both high in the same cycle.
- The source is the round-robin winner among FULL VCs, starting from the VC after the last one granted.
- The granted VC returns to IDLE at that same edge.
- While `out_packet_valid` is high and `out_packet_ready` is low, all `out_*` signals stay stable and no grant occurs.

**Enable and backpressure.**
- `enable` low means no flit is accepted or dropped, and per-VC state is frozen.
- The output handshake and arbitration continue regardless of `enable`.
- `ni_vc_full` equals per-VC state == FULL, taken directly from the registered state.

## Timing

**Reset.** All VCs go to IDLE and all counts to 0. The round-robin pointer resets to VC 0. Output values after reset:
- `out_packet_valid`=0, `out_packet_body`=0, `out_packet_vc`=0.
- `out_is_for_cc`=0, `out_is_for_dc`=0, `out_packet_truncated`=0.
- `err_flit_drop`=0, `err_vc`=0, `ni_vc_full`=0.
- A reset mid-packet discards all partial and held packets.

**Latency and throughput.**
- A TAIL or HT sampled at edge t sets FULL after t and raises `ni_vc_full` in cycle t+1.
- The output loads at edge t+1, so `out_packet_valid` is high in cycle t+2 when the output is free.
- Sustained throughput is one packet per cycle with `out_packet_ready` held high.

**Simultaneous events.**
- A flit arriving on a VC in the same cycle that VC is granted sees state FULL and is dropped. The router must honour `ni_vc_full`.
- A flit arriving on VC a while VC b is granted proceeds normally.

**Errors.** `err_flit_drop` and `err_vc` are registered, so the pulse appears in the cycle after the offending flit.

## Test plan
Use `PAYLOAD_W`=64 and `PACKET_BODY_SIZE`=256, giving `FLIT_NUMB`=4.

1. **Single HT.** HT on VC1 with payload 0xA5, TO_DC, `out_packet_ready`=1.
   - `ni_vc_full`[1] is high for 1 cycle.
   - Two cycles after the HT: valid=1, body=0xA5 with upper bits zero, vc=1, `out_is_for_dc`=1, `out_is_for_cc`=0.
2. **Interleaved VCs.** HEADER/BODY/BODY/TAIL on VC0 (payloads 1,2,3,4) interleaved flit-by-flit with the same sequence on VC2 (payloads 5,6,7,8).
   - Two packets are emitted, VC0 first.
   - Bodies are {4,3,2,1} and {8,7,6,5}, segment 0 lowest.
3. **Backpressure.**
   - Complete packets on VC0, VC1 and VC3 with `out_packet_ready`=0. The first packet is held stable and `ni_vc_full`=4'b1010.
   - Raise ready. The remaining packets follow on consecutive cycles in order VC1, VC3.
4. **Overflow.** Six flits (HEADER, 4×BODY, TAIL) on VC0.
   - The body holds the first 4 payloads.
   - `out_packet_truncated`=1 and `err_flit_drop` is never asserted.
5. **Protocol errors.**
   - BODY on IDLE VC2 gives `err_flit_drop`=1, `err_vc`=2.
   - HEADER on COLLECT VC0 gives one drop pulse, and the next TAIL yields the restarted packet only.
   - A flit on a FULL VC is dropped.
6. **Reset and enable.**
   - Assert reset after 2 flits of a packet: no packet is output and all outputs read their reset values.
   - Assert `enable`=0 during a TAIL: the TAIL is ignored and the VC remains in COLLECT.
